// File: rtl/serial_rx_framed.sv
// serial_rx_framed: async serial receiver (2-flop sync, mid-bit sampling, parity/stop/break checks) feeding a one-entry valid/ready holding register
module serial_rx_framed #(
  parameter int Width      = 8,
  parameter int TimerWidth = 16,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [TimerWidth-1:0] div,
  output logic [Width-1:0]      data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  brk,
  output logic                  overrun,
  output logic                  busy
);
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [4:0] LAST  = 5'(Width - 1);
  localparam logic [4:0] SLAST = 5'(StopBits - 1);
  state_t state, state_n;
  logic [1:0] sync;
  logic [TimerWidth-1:0] timer;
  logic [4:0] cnt;
  logic [Width-1:0] shreg;
  logic par_bad, stop_bad, first_stop;
  logic rxs, tick, commit, exp_par;
  assign rxs = sync[1];
  always_ff @(posedge clk) begin
    if (rst) state <= ARM;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      ARM:     state_n = rxs ? IDLE : ARM;
      IDLE:    state_n = rxs ? IDLE : START;
      START:   state_n = !tick ? START : rxs ? IDLE : DATA;
      DATA:    state_n = tick && cnt == LAST ? (ParityMode != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_n = tick ? STOP : PARITY;
      STOP:    state_n = tick && cnt == SLAST ? (rxs ? IDLE : ARM) : STOP;
      default: state_n = ARM;
    endcase
  end
  always_comb begin
    busy    = state == START || state == DATA || state == PARITY || state == STOP;
    tick    = busy && timer == '0;
    commit  = tick && state == STOP && cnt == SLAST;
    exp_par = ^shreg ^ (ParityMode == 2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      timer      <= '0;
      cnt        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      first_stop <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync  <= {sync[0], rx};
      timer <= state == IDLE ? div >> 1 : !busy ? '0 : tick ? div : timer - 1'b1;
      if (tick) begin
        if (state == START) begin
          cnt      <= '0;
          par_bad  <= 1'b0;
          stop_bad <= 1'b0;
        end
        if (state == DATA) begin
          shreg <= {rxs, shreg[Width-1:1]};
          cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
        end
        if (state == PARITY) par_bad <= rxs != exp_par;
        if (state == STOP) begin
          cnt      <= cnt + 1'b1;
          stop_bad <= stop_bad | ~rxs;
          if (cnt == '0) first_stop <= rxs;
        end
      end
      if (commit) begin
        data       <= shreg;
        parity_err <= par_bad;
        frame_err  <= stop_bad | ~rxs;
        brk        <= ~|shreg && !(cnt == '0 ? rxs : first_stop);
        overrun    <= valid && !ready;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_rx_framed.sv
// tb_serial_rx_framed: directed self-checking bench for an 8N1 receiver and an 8E2 receiver
module tb_serial_rx_framed;
  logic clk = 1'b0, rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, ready0 = 1'b1, ready1 = 1'b1;
  logic [15:0] div = 16'd9;
  logic [7:0] data0, data1;
  logic valid0, valid1, pe0, pe1, fe0, fe1, brk0, brk1, ov0, ov1, busy0, busy1;
  int tests = 0, fails = 0;
  logic [11:0] log0[$], log1[$];
  always #5 clk = ~clk;
  serial_rx_framed #(.Width(8), .TimerWidth(16), .ParityMode(0), .StopBits(1)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .div(div), .data(data0), .valid(valid0), .ready(ready0),
    .parity_err(pe0), .frame_err(fe0), .brk(brk0), .overrun(ov0), .busy(busy0));
  serial_rx_framed #(.Width(8), .TimerWidth(16), .ParityMode(1), .StopBits(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .div(div), .data(data1), .valid(valid1), .ready(ready1),
    .parity_err(pe1), .frame_err(fe1), .brk(brk1), .overrun(ov1), .busy(busy1));
  always @(posedge clk) begin
    if (!rst && valid0 && ready0) log0.push_back({ov0, brk0, fe0, pe0, data0});
    if (!rst && valid1 && ready1) log1.push_back({ov1, brk1, fe1, pe1, data1});
  end
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 0) rx0 = bits[i];
      else rx1 = bits[i];
      repeat (9) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({data0, valid0, pe0, fe0, brk0, ov0, busy0} !== 14'h0) begin
      $display("FAIL reset_dut0: got %h required 0", {data0, valid0, pe0, fe0, brk0, ov0, busy0});
      fails++;
    end
    tests++;
    if ({data1, valid1, pe1, fe1, brk1, ov1, busy1} !== 14'h0) begin
      $display("FAIL reset_dut1: got %h required 0", {data1, valid1, pe1, fe1, brk1, ov1, busy1});
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_8n1;
    int n = 0;
    log0.delete();
    fork
      begin
        send_bits(0, {6'h0, 1'b1, 8'h55, 1'b0}, 10);
        send_bits(0, {6'h0, 1'b1, 8'hA3, 1'b0}, 10);
      end
      begin
        @(negedge clk);
        while (n < 300) begin
          @(posedge clk);
          #1;
          n++;
          if (valid0) break;
        end
      end
    join
    repeat (20) @(negedge clk);
    tests++;
    if (n !== 98) begin
      $display("FAIL latency_8n1: got %0d clocks required 98", n);
      fails++;
    end
    tests++;
    if (log0.size() !== 2) begin
      $display("FAIL b2b_count: got %0d frames required 2", log0.size());
      fails++;
    end
    tests++;
    if (log0[0] !== 12'h055) begin
      $display("FAIL b2b_frame0: got %h required 055", log0[0]);
      fails++;
    end
    tests++;
    if (log0[1] !== 12'h0A3) begin
      $display("FAIL b2b_frame1: got %h required 0A3", log0[1]);
      fails++;
    end
  endtask
  task automatic test_false_start;
    int nb = 0, nv = 0;
    log0.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx0 = i < 3 ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      nb += int'(busy0);
      nv += int'(valid0);
    end
    repeat (100) @(negedge clk);
    tests++;
    if (nb < 1 || nb > 7) begin
      $display("FAIL false_start_busy: got %0d busy clocks required 1..7", nb);
      fails++;
    end
    tests++;
    if (busy0 !== 1'b0 || nv !== 0 || log0.size() !== 0) begin
      $display("FAIL false_start_quiet: got busy=%b valid_clocks=%0d frames=%0d required 0/0/0", busy0, nv, log0.size());
      fails++;
    end
  endtask
  task automatic test_break;
    log0.delete();
    @(negedge clk);
    rx0 = 1'b0;
    repeat (200) @(negedge clk);
    rx0 = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (log0.size() !== 1 || log0[0] !== 12'h600) begin
      $display("FAIL break_frame: got %0d frames first %h required 1 frame 600", log0.size(), log0[0]);
      fails++;
    end
    send_bits(0, {6'h0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (30) @(negedge clk);
    tests++;
    if (log0.size() !== 2 || log0[1] !== 12'h03C) begin
      $display("FAIL break_recover: got %0d frames last %h required 2 frames 03C", log0.size(), log0[1]);
      fails++;
    end
  endtask
  task automatic test_parity;
    log1.delete();
    send_bits(1, {4'h0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12);
    send_bits(1, {4'h0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12);
    repeat (20) @(negedge clk);
    tests++;
    if (log1.size() !== 2) begin
      $display("FAIL parity_count: got %0d frames required 2", log1.size());
      fails++;
    end
    tests++;
    if (log1[0] !== 12'h007) begin
      $display("FAIL parity_good: got %h required 007", log1[0]);
      fails++;
    end
    tests++;
    if (log1[1] !== 12'h107) begin
      $display("FAIL parity_bad: got %h required 107", log1[1]);
      fails++;
    end
  endtask
  task automatic test_stop2;
    log1.delete();
    send_bits(1, {4'h0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 12);
    repeat (150) @(negedge clk);
    tests++;
    if (log1.size() !== 1 || log1[0] !== 12'h25A) begin
      $display("FAIL stop2_err: got %0d frames first %h required 1 frame 25A", log1.size(), log1[0]);
      fails++;
    end
    tests++;
    if (busy1 !== 1'b0) begin
      $display("FAIL stop2_armed: got busy=%b required 0", busy1);
      fails++;
    end
    rx1 = 1'b1;
    repeat (20) @(negedge clk);
    send_bits(1, {4'h0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12);
    repeat (30) @(negedge clk);
    tests++;
    if (log1.size() !== 2 || log1[1] !== 12'h03C) begin
      $display("FAIL stop2_recover: got %0d frames last %h required 2 frames 03C", log1.size(), log1[1]);
      fails++;
    end
  endtask
  task automatic test_overrun;
    log0.delete();
    ready0 = 1'b0;
    send_bits(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (20) @(negedge clk);
    tests++;
    if ({valid0, ov0, brk0, fe0, pe0, data0} !== 13'h1822) begin
      $display("FAIL overrun_held: got %h required 1822", {valid0, ov0, brk0, fe0, pe0, data0});
      fails++;
    end
    tests++;
    if (log0.size() !== 0) begin
      $display("FAIL overrun_nohs: got %0d frames required 0", log0.size());
      fails++;
    end
    @(negedge clk);
    ready0 = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({valid0, ov0, data0} !== 10'h022) begin
      $display("FAIL overrun_clear: got %h required 022", {valid0, ov0, data0});
      fails++;
    end
    tests++;
    if (log0.size() !== 1 || log0[0] !== 12'h822) begin
      $display("FAIL overrun_hs: got %0d frames first %h required 1 frame 822", log0.size(), log0[0]);
      fails++;
    end
  endtask
  task automatic test_reset_mid;
    ready0 = 1'b0;
    send_bits(0, {6'h0, 1'b1, 8'h44, 1'b0}, 10);
    repeat (20) @(negedge clk);
    tests++;
    if (valid0 !== 1'b1 || data0 !== 8'h44) begin
      $display("FAIL rst_pre_hold: got valid=%b data=%h required 1/44", valid0, data0);
      fails++;
    end
    fork
      send_bits(0, {6'h0, 1'b1, 8'h99, 1'b0}, 10);
      begin
        repeat (50) @(negedge clk);
        tests++;
        if (busy0 !== 1'b1) begin
          $display("FAIL rst_midframe_busy: got %b required 1", busy0);
          fails++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({data0, valid0, pe0, fe0, brk0, ov0, busy0} !== 14'h0) begin
          $display("FAIL rst_midframe: got %h required 0", {data0, valid0, pe0, fe0, brk0, ov0, busy0});
          fails++;
        end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    ready0 = 1'b1;
  endtask
  initial begin
    test_reset;
    test_8n1;
    test_false_start;
    test_break;
    test_parity;
    test_stop2;
    test_overrun;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within 1000000 ns");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_rx_framed.md
Name: serial_rx_framed

Overview:
Parametrised asynchronous serial receiver, successor to the fixed 8N1 receiver in the io library.
- Adds runtime baud divisor and a two-flop input synchroniser.
- Mid-bit sampling with false-start rejection.
- Optional even/odd parity and 1 or 2 stop bits.
- Error, break and overrun flags.
- One-entry output holding register with a valid/ready handshake.
Sits between the pad-level rx line and any byte/word consumer (FIFO, command decoder).

Parameters:
Width, 8, data bits per frame (5..16), LSB first on the line
TimerWidth, 16, width of baud divisor and bit timer
ParityMode, 0, 0 = none, 1 = even, 2 = odd
StopBits, 1, number of stop bits checked (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial line, idle high
div  in  TimerWidth  bit period minus one, in clocks (bit period = div+1); must be >= 3 and stable while busy
data  out  Width  received data word
valid  out  1  data/flags hold a completed frame
ready  in  1  consumer accepts data when valid&&ready
parity_err  out  1  parity mismatch on the held frame
frame_err  out  1  any stop bit sampled 0 on the held frame
brk  out  1  break: data all zero and first stop bit 0
overrun  out  1  held frame overwrote an unconsumed one
busy  out  1  high in START/DATA/PARITY/STOP

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - state=ARM, timer=0, bit count=0, synchroniser flops=1.
  - All outputs 0: data=0, valid=0, parity_err=0, frame_err=0, brk=0, overrun=0, busy=0.
  - rst mid-frame aborts the frame and discards partial data; a held frame is also lost.
- Synchroniser: rx passes through 2 flops (rxs). Every decision below uses rxs only.
- States:
  - ARM: wait for rxs=1, then -> IDLE. Prevents a stuck-low line from looking like start bits.
  - IDLE: on rxs=0 -> START, load timer=div>>1.
  - Timer rule, all timed states: if timer!=0, decrement. If timer==0, sample rxs and reload timer=div. Sample spacing is therefore div+1 clocks.
  - START: at the sample, rxs=1 -> IDLE (false start, nothing reported). rxs=0 -> DATA, bit count=0.
  - DATA: at each sample, shift rxs into bit[count], LSB first. After Width samples -> PARITY if ParityMode!=0, else -> STOP.
  - PARITY: at the sample, compare rxs with the expected bit: XOR of the data bits for even, its inverse for odd. Mismatch sets a pending parity error. -> STOP.
  - STOP: sample StopBits times; any 0 sets a pending frame error. After the last stop sample, commit the frame (below). Next state is IDLE if the last stop sample was 1, else ARM.
- Commit, registered on the last stop-sample edge, so visible the next cycle:
  - data <= shifted word; parity_err, frame_err <= pending values.
  - brk <= (word==0) && first stop bit==0.
  - overrun <= valid && !ready.
  - valid <= 1.
- Handshake:
  - valid holds until valid&&ready at a clk edge, which clears valid and overrun. data and the error flags keep their values.
  - A commit in the same cycle as a handshake loads the new frame, keeps valid=1 and sets overrun=0.
- Back-to-back frames: IDLE is entered immediately after the stop sample. A start edge arriving in the remaining half stop bit is accepted.
- busy=1 exactly when state is START, DATA, PARITY or STOP.
- Frame latency: valid rises 2 (sync) + (div>>1) + (1+Width+P+StopBits-1)*(div+1) + 2 clocks after the line's falling edge, where P=1 if parity is enabled.
- A div change while busy is not supported. div is sampled at each timer reload.

Test Plan:
- 8N1, div=9: send 0x55 then 0xA3 back-to-back, ready=1 -> two valid pulses, data=0x55 then 0xA3, all error flags 0. First valid rises 98 clocks after the falling edge.
- False start: 3-clock low glitch on idle rx, div=9 -> state returns to IDLE, valid stays 0, busy high for at most 7 clocks.
- ParityMode=1: send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> parity_err=0 for the first frame, parity_err=1 for the second, data=0x07 both times.
- StopBits=2, second stop bit driven 0 -> frame_err=1, brk=0, receiver goes to ARM and next accepts a frame only after rx returns high.
- Break: rx held low for 20 bit periods -> one frame with data=0x00, frame_err=1, brk=1. No further frames until rx goes high, then a normal 0x3C frame is received cleanly.
- Overrun and reset: ready=0, send 0x11 then 0x22 -> data=0x22, overrun=1. Then ready=1 for one clock -> valid=0, overrun=0. Assert rst mid-frame -> all outputs 0 next cycle, state ARM.
